// File: rtl/capture_pkg.sv
// Shared types and helpers for the triggered capture buffer.
package capture_pkg;

   localparam int TIMESTEP_SEL_W = 3;
   // Wide enough to hold the longest sample period (2**7 clocks).
   localparam int TICK_CNT_W     = (1 << TIMESTEP_SEL_W) - 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4
   } capture_state_t;

   // True while the buffer owns the RAM port.
   function automatic logic is_capturing(input capture_state_t s);
      return (s == PRE) || (s == ARMED) || (s == POST);
   endfunction

   // Low bits of the tick counter that must be zero for a sample tick.
   function automatic logic [TICK_CNT_W-1:0] tick_mask(input logic [TIMESTEP_SEL_W-1:0] sel);
      return TICK_CNT_W'((32'd1 << sel) - 32'd1);
   endfunction

endpackage

// File: rtl/block_ram.sv
// Single-port block RAM with registered read (read-before-write).
module block_ram #(
   parameter int RAM_WIDTH     = 8,
   parameter int RAM_ADDR_BITS = 8
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [RAM_ADDR_BITS-1:0] addr,
   input  logic [RAM_WIDTH-1:0]     wr_data,
   output logic [RAM_WIDTH-1:0]     rd_data
);

   logic [RAM_WIDTH-1:0] mem [2**RAM_ADDR_BITS];
   logic [RAM_WIDTH-1:0] rd_data_q;

   // Storage write plus synchronous read of the addressed word.
   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= wr_data;
      rd_data_q <= mem[addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/capture_buffer.sv
// Triggered multi-channel capture buffer (logic-analyser style).
// Optional build macro CAPTURE_ANY_EDGE_EN adds cfg_edge_mask: a change on any
// masked probe bit between ticks also counts as a trigger event.
// Read port: rd_enable is a one-cycle strobe; rd_data carries RAM[rd_address]
// on the following cycle, and is zero whenever no read was accepted.
module capture_buffer
   import capture_pkg::*;
#(
   parameter int NUM_CH        = 8,
   parameter int RAM_ADDR_BITS = 8
) (
   input  logic                      clk,
   input  logic                      rst_n_sync,
   input  logic [NUM_CH-1:0]         probe_in,
   input  logic                      trigger_in,
   input  logic                      cfg_enable,
   input  logic [RAM_ADDR_BITS-1:0]  cfg_pretrig_count,
   input  logic [TIMESTEP_SEL_W-1:0] cfg_timestep_sel,
`ifdef CAPTURE_ANY_EDGE_EN
   input  logic [NUM_CH-1:0]         cfg_edge_mask,
`endif
   input  logic                      rd_enable,
   input  logic [RAM_ADDR_BITS-1:0]  rd_address,
   output logic [NUM_CH-1:0]         rd_data,
   output logic                      capture_active,
   output logic                      capture_done,
   output logic [RAM_ADDR_BITS-1:0]  trig_address,
   output logic [RAM_ADDR_BITS-1:0]  start_address,
   output capture_state_t            dbg_state
);

   localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'((1 << RAM_ADDR_BITS) - 1);

   capture_state_t              state_q, state_d;
   logic [RAM_ADDR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
   logic [RAM_ADDR_BITS-1:0]    pre_cnt_q, pre_cnt_d;
   logic [RAM_ADDR_BITS-1:0]    post_cnt_q, post_cnt_d;
   logic [TICK_CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
   logic                        pending_q, pending_d;
   logic                        trig_prev_q, trig_prev_d;
   logic [RAM_ADDR_BITS-1:0]    trig_addr_q, trig_addr_d;
   logic [RAM_ADDR_BITS-1:0]    pretrig_q, pretrig_d;
   logic [TIMESTEP_SEL_W-1:0]   sel_q, sel_d;
   logic                        rd_valid_q, rd_valid_d;
`ifdef CAPTURE_ANY_EDGE_EN
   logic [NUM_CH-1:0]           edge_mask_q, edge_mask_d;
   logic [NUM_CH-1:0]           probe_prev_q, probe_prev_d;
`endif

   logic                        capturing, tick, trig_rise, trig_event, pre_full;
   logic [RAM_ADDR_BITS-1:0]    pre_cnt_inc, ram_addr;
   logic [NUM_CH-1:0]           ram_rd_data;
   logic                        wr_req, wr_en;

   assign capturing   = is_capturing(state_q);
   assign tick        = capturing && ((tick_cnt_q & tick_mask(sel_q)) == '0);
   assign trig_rise   = trigger_in && !trig_prev_q;
   assign pre_full    = (pre_cnt_q == pretrig_q);
   assign pre_cnt_inc = pre_cnt_q + 1'b1;
`ifdef CAPTURE_ANY_EDGE_EN
   assign trig_event  = pending_q || trig_rise || (|((probe_in ^ probe_prev_q) & edge_mask_q));
`else
   assign trig_event  = pending_q || trig_rise;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n_sync) state_q <= IDLE;
      else             state_q <= state_d;
   end

   // FSM next state; dropping cfg_enable aborts from anywhere.
   always_comb begin
      state_d = state_q;
      if (!cfg_enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = PRE;
            PRE:     if (pre_full || (tick && pre_cnt_inc == pretrig_q)) state_d = ARMED;
            ARMED:   if (tick && trig_event) state_d = POST;
            POST:    if (tick && post_cnt_q == '0) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs.
   always_comb begin
      capture_active = capturing;
      capture_done   = (state_q == DONE);
      dbg_state      = state_q;
   end

   // Datapath next values: config latch, counters, write pointer, trigger capture.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      pre_cnt_d   = pre_cnt_q;
      post_cnt_d  = post_cnt_q;
      tick_cnt_d  = tick_cnt_q;
      pending_d   = pending_q;
      trig_prev_d = trigger_in;
      trig_addr_d = trig_addr_q;
      pretrig_d   = pretrig_q;
      sel_d       = sel_q;
      rd_valid_d  = rd_enable && !capturing;
      wr_req      = 1'b0;
`ifdef CAPTURE_ANY_EDGE_EN
      edge_mask_d  = edge_mask_q;
      probe_prev_d = tick ? probe_in : probe_prev_q;
`endif
      case (state_q)
         IDLE: begin
            if (cfg_enable) begin
               wr_ptr_d   = '0;
               pre_cnt_d  = '0;
               tick_cnt_d = '0;
               pending_d  = 1'b0;
               pretrig_d  = cfg_pretrig_count;
               sel_d      = cfg_timestep_sel;
`ifdef CAPTURE_ANY_EDGE_EN
               edge_mask_d  = cfg_edge_mask;
               probe_prev_d = probe_in;
`endif
            end
         end
         PRE: begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            if (tick && !pre_full) begin
               wr_req    = 1'b1;
               pre_cnt_d = pre_cnt_inc;
            end
         end
         ARMED: begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            if (tick) begin
               wr_req = 1'b1;
               if (trig_event) begin
                  trig_addr_d = wr_ptr_q;
                  post_cnt_d  = LAST_IDX - pretrig_q;
                  pending_d   = 1'b0;
               end
            end else if (trig_rise) begin
               pending_d = 1'b1;
            end
         end
         POST: begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            if (tick && post_cnt_q != '0) begin
               wr_req     = 1'b1;
               post_cnt_d = post_cnt_q - 1'b1;
            end
         end
         default: ;
      endcase
      // No write on the clock that aborts or resets the capture.
      wr_en = wr_req && cfg_enable && rst_n_sync;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n_sync) begin
         wr_ptr_q     <= '0;
         pre_cnt_q    <= '0;
         post_cnt_q   <= '0;
         tick_cnt_q   <= '0;
         pending_q    <= 1'b0;
         trig_prev_q  <= 1'b0;
         trig_addr_q  <= '0;
         pretrig_q    <= '0;
         sel_q        <= '0;
         rd_valid_q   <= 1'b0;
`ifdef CAPTURE_ANY_EDGE_EN
         edge_mask_q  <= '0;
         probe_prev_q <= '0;
`endif
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         pre_cnt_q    <= pre_cnt_d;
         post_cnt_q   <= post_cnt_d;
         tick_cnt_q   <= tick_cnt_d;
         pending_q    <= pending_d;
         trig_prev_q  <= trig_prev_d;
         trig_addr_q  <= trig_addr_d;
         pretrig_q    <= pretrig_d;
         sel_q        <= sel_d;
         rd_valid_q   <= rd_valid_d;
`ifdef CAPTURE_ANY_EDGE_EN
         edge_mask_q  <= edge_mask_d;
         probe_prev_q <= probe_prev_d;
`endif
      end
   end

   // Capture owns the single RAM port while active.
   assign ram_addr = capturing ? wr_ptr_q : rd_address;

   block_ram #(
      .RAM_WIDTH     (NUM_CH),
      .RAM_ADDR_BITS (RAM_ADDR_BITS)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .addr    (ram_addr),
      .wr_data (probe_in),
      .rd_data (ram_rd_data)
   );

   assign rd_data       = rd_valid_q ? ram_rd_data : '0;
   assign trig_address  = trig_addr_q;
   assign start_address = trig_addr_q - pretrig_q;

endmodule

// File: tb/tb_capture_buffer.sv
// Bench for capture_buffer (NUM_CH=8, RAM_ADDR_BITS=8, probe_in = free-running count).
module tb_capture_buffer;
   import capture_pkg::*;

   localparam int DEPTH   = 256;
   localparam int LOG_MAX = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rst_n_sync;
   logic [7:0]                probe_in;
   logic                      trigger_in;
   logic                      cfg_enable;
   logic [7:0]                cfg_pretrig_count;
   logic [TIMESTEP_SEL_W-1:0] cfg_timestep_sel;
`ifdef CAPTURE_ANY_EDGE_EN
   logic [7:0]                cfg_edge_mask;
`endif
   logic                      rd_enable;
   logic [7:0]                rd_address;
   logic [7:0]                rd_data;
   logic                      capture_active;
   logic                      capture_done;
   logic [7:0]                trig_address;
   logic [7:0]                start_address;
   capture_state_t            dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_mem  [DEPTH];
   logic [7:0] probe_at [LOG_MAX];
   logic [7:0] exp_q    [$];

   typedef struct {
      int pretrig;
      int sel;
      int t0;
      int t1;
      int exp_trig;
      int exp_start;
   } vec_t;
   vec_t vecs [7];

   capture_buffer #(.NUM_CH(8), .RAM_ADDR_BITS(8)) dut (
      .clk               (clk),
      .rst_n_sync        (rst_n_sync),
      .probe_in          (probe_in),
      .trigger_in        (trigger_in),
      .cfg_enable        (cfg_enable),
      .cfg_pretrig_count (cfg_pretrig_count),
      .cfg_timestep_sel  (cfg_timestep_sel),
`ifdef CAPTURE_ANY_EDGE_EN
      .cfg_edge_mask     (cfg_edge_mask),
`endif
      .rd_enable         (rd_enable),
      .rd_address        (rd_address),
      .rd_data           (rd_data),
      .capture_active    (capture_active),
      .capture_done      (capture_done),
      .trig_address      (trig_address),
      .start_address     (start_address),
      .dbg_state         (dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock; outputs are stable #1 after the edge, then the probe count advances.
   task automatic clk1();
      @(posedge clk);
      #1;
      probe_in = probe_in + 8'd1;
   endtask

   // Tick index (ticks at clocks k*T after PRE entry) at which a trigger is honoured.
   function automatic int honored_tick(input int p, input int t, input int t0, input int t1);
      int armed_at;
      armed_at = (p == 0) ? 1 : (p - 1) * t + 1;
      if (t0 >= armed_at) return (t0 + t - 1) / t;
      if (t1 >= armed_at) return (t1 + t - 1) / t;
      return -1;
   endfunction

   task automatic readback();
      rd_enable = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         rd_address = 8'(a);
         exp_q.push_back(exp_mem[a]);
         clk1();
         check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(exp_q.pop_front()));
      end
      rd_enable = 1'b0;
      clk1();
      check("rd_data_idle_zero", 32'(rd_data), 32'd0);
   endtask

   // mode 0: full capture; 1: cfg_enable dropped at stop_rel; 2: reset at stop_rel.
   task automatic run_capture(input int p, input int sel, input int t0, input int t1,
                              input int mode, input int stop_rel, input int force_j,
                              output int w_trig);
      int t, skip, j, done_rel, end_rel, last_k;
      t        = 1 << sel;
      skip     = (p == 0) ? 1 : 0;
      j        = (force_j >= 0) ? force_j : honored_tick(p, t, t0, t1);
      done_rel = (j + DEPTH - p) * t;
      end_rel  = (mode == 0) ? done_rel : stop_rel;
      w_trig   = j - skip;
      if (j < 0 || end_rel >= LOG_MAX - 1) begin
         n_checks++;
         n_fail++;
         $display("FAIL run_budget: got end_rel %0d, required below %0d", end_rel, LOG_MAX - 1);
         return;
      end
      cfg_pretrig_count = 8'(p);
      cfg_timestep_sel  = TIMESTEP_SEL_W'(sel);
      cfg_enable        = 1'b1;
      trigger_in        = 1'b0;
      clk1();
      rd_enable = 1'b1;
      for (int r = 0; r <= end_rel; r++) begin
         if (mode == 1 && r == stop_rel) cfg_enable = 1'b0;
         if (mode == 2 && r == stop_rel) rst_n_sync = 1'b0;
         trigger_in  = (r == t0) || (r == t1);
         rd_address  = 8'($urandom_range(0, 255));
         probe_at[r] = probe_in;
         clk1();
         if (r < end_rel) begin
            check("active_during_capture", 32'(capture_active), 32'd1);
            check("rd_data_zero_while_active", 32'(rd_data), 32'd0);
         end
      end
      trigger_in = 1'b0;
      rd_enable  = 1'b0;
      // Every tick of the run writes the next address, except a pretrig=0 PRE tick.
      last_k = j + DEPTH - 1 - p;
      for (int k = skip; k <= last_k; k++) begin
         if (k * t < end_rel) exp_mem[(k - skip) & 255] = probe_at[k * t];
      end
      if (mode == 0) begin
         check("done_flag", 32'(capture_done), 32'd1);
         check("active_after_done", 32'(capture_active), 32'd0);
         check("state_done", 32'(dbg_state), 32'(DONE));
         check("model_trig_address", 32'(trig_address), 32'(w_trig & 255));
         check("model_start_address", 32'(start_address), 32'((w_trig - p) & 255));
         readback();
         cfg_enable = 1'b0;
         clk1();
         check("done_clears", 32'(capture_done), 32'd0);
         check("active_idle", 32'(capture_active), 32'd0);
      end else if (mode == 1) begin
         check("abort_active", 32'(capture_active), 32'd0);
         check("abort_done", 32'(capture_done), 32'd0);
         check("abort_state", 32'(dbg_state), 32'(IDLE));
         check("abort_trig_kept", 32'(trig_address), 32'(w_trig & 255));
         readback();
      end else begin
         check("rst_active", 32'(capture_active), 32'd0);
         check("rst_done", 32'(capture_done), 32'd0);
         check("rst_trig", 32'(trig_address), 32'd0);
         check("rst_start", 32'(start_address), 32'd0);
         check("rst_rd_data", 32'(rd_data), 32'd0);
         rst_n_sync = 1'b1;
         cfg_enable = 1'b0;
         clk1();
         readback();
      end
   endtask

   initial begin
      int w, p, sel, t, armed_at, t0, t1;
      rst_n_sync        = 1'b0;
      probe_in          = 8'd0;
      trigger_in        = 1'b0;
      cfg_enable        = 1'b0;
      cfg_pretrig_count = 8'd0;
      cfg_timestep_sel  = '0;
`ifdef CAPTURE_ANY_EDGE_EN
      cfg_edge_mask     = 8'd0;
`endif
      rd_enable         = 1'b0;
      rd_address        = 8'd0;
      repeat (3) clk1();
      check("reset_active", 32'(capture_active), 32'd0);
      check("reset_done", 32'(capture_done), 32'd0);
      check("reset_trig", 32'(trig_address), 32'd0);
      check("reset_start", 32'(start_address), 32'd0);
      check("reset_rd_data", 32'(rd_data), 32'd0);
      check("reset_state", 32'(dbg_state), 32'(IDLE));
      rst_n_sync = 1'b1;
      clk1();

      // {pretrig, sel, trigger clocks after PRE entry, expected trig/start address}
      vecs[0] = '{16,  0, 100,  -1, 100,  84};
      vecs[1] = '{32,  0,   5,  50,  50,  18};
      vecs[2] = '{4,   3,  45,  -1,   6,   2};
      vecs[3] = '{0,   0,  10,  -1,   9,   9};
      vecs[4] = '{255, 0, 300,  -1,  44,  45};
      vecs[5] = '{8,   1,   2,  40,  20,  12};
      vecs[6] = '{10,  2,  48,  -1,  12,   2};
      for (int i = 0; i < 7; i++) begin
         run_capture(vecs[i].pretrig, vecs[i].sel, vecs[i].t0, vecs[i].t1, 0, 0, -1, w);
         check($sformatf("vec%0d_trig_address", i), 32'(trig_address), 32'(vecs[i].exp_trig));
         check($sformatf("vec%0d_start_address", i), 32'(start_address), 32'(vecs[i].exp_start));
      end

      // Abort in POST, then a fresh run must restart from address 0.
      run_capture(16, 0, 100, -1, 1, 150, -1, w);
      run_capture(16, 0, 40, -1, 0, 0, -1, w);
      check("restart_trig_address", 32'(trig_address), 32'd40);
      check("restart_start_address", 32'(start_address), 32'd24);

      // Reset in POST: outputs clear and the remaining RAM is untouched.
      run_capture(16, 0, 100, -1, 2, 150, -1, w);

`ifdef CAPTURE_ANY_EDGE_EN
      // Bit0 of the count toggles every clock, so the first ARMED tick triggers.
      cfg_edge_mask = 8'h01;
      run_capture(4, 0, -1, -1, 0, 0, 4, w);
      check("edge_trig_address", 32'(trig_address), 32'd4);
      check("edge_start_address", 32'(start_address), 32'd0);
      cfg_edge_mask = 8'h00;
`endif

      for (int n = 0; n < 4; n++) begin
         p        = int'($urandom_range(0, 255));
         sel      = int'($urandom_range(0, 2));
         t        = 1 << sel;
         armed_at = (p == 0) ? 1 : (p - 1) * t + 1;
         t0       = int'($urandom_range(0, armed_at + 50));
         t1       = ((t0 + 2 > armed_at) ? t0 + 2 : armed_at) + int'($urandom_range(0, 60));
         run_capture(p, sel, t0, t1, 0, 0, -1, w);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
